mem_march_tester: RTL and testbench

MEM_MARCH_TESTER -- requirements
Module: mem_march_tester

---
 rtl/mem_march_tester.sv | 162 ++++++++++++++++
 tb/tb_mem_march_tester.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_march_tester.sv
// rtl/mem_march_tester.sv - March C- self-test engine for a small single-port RAM
//
// Runs E0 up W(0) / E1 up R(0),W(1) / E2 down R(1),W(0) / E3 up R(0),
// one RAM operation per clock, and stops at the first read mismatch.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             run one pass; only looked at in IDLE or DONE
//   mem_we/addr/din   RAM write enable, address, write data (registered)
//   mem_dout          RAM read data, combinational on mem_addr
//   busy, done, pass  pass in progress / pass finished / no mismatch seen
//   fail_addr/data    address and read data of the first mismatch
//   fail_elem         march element (1..3) of the first mismatch

module mem_march_tester #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [1:0]        fail_elem
);

  typedef enum logic [2:0] {S_IDLE, S_E0, S_E1, S_E2, S_E3, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [DATA_W-1:0] P0 = '0;
  localparam logic [DATA_W-1:0] P1 = '1;

  state_t            state, nxt_state;
  logic              sub, nxt_sub;       // E1/E2: 0 = READ, 1 = WRITE
  logic [ADDR_W-1:0] nxt_addr;
  logic              rd_cycle, mismatch, finish_ok, accept;
  logic [DATA_W-1:0] exp_data;
  logic [1:0]        elem_idx;

  always_comb begin
    rd_cycle  = ((state == S_E1 || state == S_E2) && !sub) || (state == S_E3);
    exp_data  = (state == S_E2) ? P1 : P0;
    mismatch  = rd_cycle && (mem_dout != exp_data);
    accept    = (state == S_IDLE || state == S_DONE) && start;
    finish_ok = 1'b0;
    nxt_state = state;
    nxt_addr  = mem_addr;
    nxt_sub   = sub;

    case (state)
      S_E1:    elem_idx = 2'd1;
      S_E2:    elem_idx = 2'd2;
      S_E3:    elem_idx = 2'd3;
      default: elem_idx = 2'd0;
    endcase

    case (state)
      S_IDLE, S_DONE: begin
        if (start) nxt_state = S_E0;
      end
      S_E0: begin
        if (mem_addr == ADDR_MAX) begin
          nxt_state = S_E1;
          nxt_addr  = '0;
        end else begin
          nxt_addr = mem_addr + 1'b1;
        end
      end
      S_E1: begin
        if (!sub) begin
          if (mismatch) nxt_state = S_DONE;
          else          nxt_sub   = 1'b1;
        end else begin
          nxt_sub = 1'b0;
          if (mem_addr == ADDR_MAX) begin
            nxt_state = S_E2;    // E2 starts at the top address
          end else begin
            nxt_addr = mem_addr + 1'b1;
          end
        end
      end
      S_E2: begin
        if (!sub) begin
          if (mismatch) nxt_state = S_DONE;
          else          nxt_sub   = 1'b1;
        end else begin
          nxt_sub = 1'b0;
          if (mem_addr == '0) begin
            nxt_state = S_E3;    // address already 0 for the ascending E3
          end else begin
            nxt_addr = mem_addr - 1'b1;
          end
        end
      end
      S_E3: begin
        if (mismatch) begin
          nxt_state = S_DONE;
        end else if (mem_addr == ADDR_MAX) begin
          nxt_state = S_DONE;
          finish_ok = 1'b1;
        end else begin
          nxt_addr = mem_addr + 1'b1;
        end
      end
      default: nxt_state = S_IDLE;
    endcase

    // IDLE/DONE park the RAM port at address 0 with no write.
    if (nxt_state == S_IDLE || nxt_state == S_DONE) begin
      nxt_addr = '0;
      nxt_sub  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sub       <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_elem <= '0;
    end else begin
      state    <= nxt_state;
      sub      <= nxt_sub;
      mem_addr <= nxt_addr;
      // Port outputs are decoded from the next state so they line up with it.
      mem_we   <= (nxt_state == S_E0) ||
                  ((nxt_state == S_E1 || nxt_state == S_E2) && nxt_sub);
      mem_din  <= (nxt_state == S_E1 && nxt_sub) ? P1 : P0;
      busy     <= (nxt_state == S_E0) || (nxt_state == S_E1) ||
                  (nxt_state == S_E2) || (nxt_state == S_E3);
      done     <= (nxt_state == S_DONE);
      if (accept) begin
        pass      <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
        fail_elem <= '0;
      end else if (mismatch) begin
        pass      <= 1'b0;
        fail_addr <= mem_addr;
        fail_data <= mem_dout;
        fail_elem <= elem_idx;
      end else if (finish_ok) begin
        pass <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_march_tester.sv
// tb/tb_mem_march_tester.sv - scoreboard bench for mem_march_tester

module tb_mem_march_tester;

  localparam int AW = 2;
  localparam int DW = 3;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic [1:0]    fail_elem;

  mem_march_tester #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .fail_elem (fail_elem)
  );

  always #5 clk = ~clk;

  // RAM model: fault 1 = bit 1 of word 2 stuck at 0, fault 2 = write to 1 also lands in 3.
  logic [DW-1:0] ram [NW];
  int            fault;

  always @(posedge clk) begin
    if (mem_we) begin
      if (fault == 1 && mem_addr == 2'd2) ram[mem_addr] <= mem_din & 3'b101;
      else                                ram[mem_addr] <= mem_din;
      if (fault == 2 && mem_addr == 2'd1) ram[3] <= mem_din;
    end
  end

  assign mem_dout = ram[mem_addr];

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } op_t;

  op_t   exp_q[$];
  int    checks;
  int    failures;
  string cur;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s/%s: got %0h expected %0h", cur, tag, obs, exp);
    end
  endtask

  // Golden March C- op list, truncated to the first n operations.
  task automatic push_ops(input int n);
    op_t all[$];
    for (int a = 0; a < NW; a++) all.push_back({1'b1, 2'(a), 3'b000});
    for (int a = 0; a < NW; a++) begin
      all.push_back({1'b0, 2'(a), 3'b000});
      all.push_back({1'b1, 2'(a), 3'b111});
    end
    for (int a = NW - 1; a >= 0; a--) begin
      all.push_back({1'b0, 2'(a), 3'b000});
      all.push_back({1'b1, 2'(a), 3'b000});
    end
    for (int a = 0; a < NW; a++) all.push_back({1'b0, 2'(a), 3'b000});
    for (int i = 0; i < n; i++) exp_q.push_back(all[i]);
  endtask

  task automatic drain_ops();
    op_t o;
    while (exp_q.size() > 0) begin
      o = exp_q.pop_front();
      check_eq("busy", 32'(busy), 32'd1);
      check_eq("done_low", 32'(done), 32'd0);
      check_eq("we", 32'(mem_we), 32'(o.we));
      check_eq("addr", 32'(mem_addr), 32'(o.addr));
      if (o.we) check_eq("din", 32'(mem_din), 32'(o.din));
      @(negedge clk);
    end
  endtask

  task automatic check_end(input logic exp_pass, input int fa, input int fd, input int fe);
    check_eq("end_done", 32'(done), 32'd1);
    check_eq("end_busy", 32'(busy), 32'd0);
    check_eq("end_pass", 32'(pass), 32'(exp_pass));
    check_eq("end_we", 32'(mem_we), 32'd0);
    check_eq("end_addr", 32'(mem_addr), 32'd0);
    check_eq("end_din", 32'(mem_din), 32'd0);
    check_eq("fail_addr", 32'(fail_addr), 32'(fa));
    check_eq("fail_data", 32'(fail_data), 32'(fd));
    check_eq("fail_elem", 32'(fail_elem), 32'(fe));
  endtask

  task automatic run_pass(input int nops, input logic exp_pass, input int fa, input int fd, input int fe);
    @(negedge clk);
    push_ops(nops);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("fail_cleared", 32'(fail_elem), 32'd0);
    drain_ops();
    check_end(exp_pass, fa, fd, fe);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    fault    = 0;
    rst      = 1'b1;
    start    = 1'b0;
    cur      = "reset";
    repeat (2) @(negedge clk);
    check_eq("busy", 32'(busy), 32'd0);
    check_eq("done", 32'(done), 32'd0);
    check_eq("pass", 32'(pass), 32'd0);
    check_eq("we", 32'(mem_we), 32'd0);
    check_eq("addr", 32'(mem_addr), 32'd0);
    check_eq("din", 32'(mem_din), 32'd0);
    check_eq("fail_addr", 32'(fail_addr), 32'd0);
    check_eq("fail_data", 32'(fail_data), 32'd0);
    check_eq("fail_elem", 32'(fail_elem), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_done", 32'(done), 32'd0);

    cur = "good";
    run_pass(24, 1'b1, 0, 0, 0);

    cur = "stuck";
    fault = 1;
    run_pass(15, 1'b0, 2, 3'b101, 2);

    cur = "alias";
    fault = 2;
    run_pass(11, 1'b0, 3, 3'b111, 1);

    cur = "good2";
    fault = 0;
    run_pass(24, 1'b1, 0, 0, 0);

    cur = "start_held";
    @(negedge clk);
    push_ops(24);
    start = 1'b1;
    @(negedge clk);
    drain_ops();
    check_end(1'b1, 0, 0, 0);
    @(negedge clk);
    check_eq("restart_busy", 32'(busy), 32'd1);
    check_eq("restart_done", 32'(done), 32'd0);
    check_eq("restart_we", 32'(mem_we), 32'd1);
    check_eq("restart_addr", 32'(mem_addr), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check_eq("held_addr", 32'(mem_addr), 32'(i));
      check_eq("held_busy", 32'(busy), 32'd1);
    end
    start = 1'b0;
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    check_eq("second_done", 32'(done), 32'd1);
    check_eq("second_pass", 32'(pass), 32'd1);

    cur = "mid_reset";
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_idle", 32'(busy), 32'd0);
    run_pass(24, 1'b1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
